// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and elaboration helpers for the UART blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

  // Parity modes selectable by the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Receive FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Ceiling log2, usable in constant expressions for counter/pointer widths
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Consumer-side bundle of the oversampled UART receiver (data, flags, handshake).
// Latency: n/a (wiring only).
// Backpressure: consumer drives ready; receiver holds the head entry until ready.
interface uart_rx_os_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_out;
  logic             perr_out;
  logic             ferr_out;
  logic             valid;
  logic             ready;
  logic             overrun;
  logic             busy;

  // Receiver side: produces entries and status, observes ready
  modport master (
    output data_out,
    output perr_out,
    output ferr_out,
    output valid,
    output overrun,
    output busy,
    input  ready
  );

  // Consumer side: observes entries and status, drives ready
  modport slave (
    input  data_out,
    input  perr_out,
    input  ferr_out,
    input  valid,
    input  overrun,
    input  busy,
    output ready
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible while empty=0.
// Latency: a push into an empty FIFO is visible on rd_dat the next cycle.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot being written, so push-while-full succeeds alongside it
  assign w_wr_en = push && (!full || pop);
  assign w_rd_en = pop && !empty;

  // Head is forced to zero when empty so stale storage never leaks out
  assign rd_dat = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because empty gates the output
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver with 3-sample majority, parity/framing flags and FWFT output FIFO.
// Latency: entry pushed on the count-9 tick of the last stop bit, valid one clk later.
// Backpressure: ready stalls the FIFO; a frame completing while full is dropped with an overrun pulse.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 16000000,
  parameter int BAUD       = 9600,
  parameter int WIDTH      = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_in,
  uart_rx_os_if.master  rx_if
);

  localparam int DIV16 = CLOCK_FREQ / (BAUD * 16);
  localparam int TW    = clog2(DIV16);
  localparam int BW    = clog2(WIDTH);
  localparam int EW    = WIDTH + 2;

  // Line synchronizer and edge-detect copy; all idle high
  logic r_sync1;
  logic r_s;
  logic r_s_d;

  // Receive state
  rx_state_t        r_state;
  logic [TW-1:0]    r_tick_cnt;
  logic [3:0]       r_samp_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_stop_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_perr;
  logic             r_ferr;
  logic             r_busy;
  logic             r_s7;
  logic             r_s8;

  // Decode of counters and the bit decision
  logic             w_tick;
  logic             w_decide;
  logic             w_bit_end;
  logic             w_maj;
  logic             w_par_x;
  logic             w_par_err;
  logic             w_last_stop;
  logic             w_start_edge;

  // FIFO side
  logic             w_push;
  logic [EW-1:0]    w_push_dat;
  logic             w_pop;
  logic [EW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;

  assign w_tick       = (r_state != ST_IDLE) && (r_tick_cnt == TW'(DIV16 - 1));
  assign w_decide     = w_tick && (r_samp_cnt == 4'd9);
  assign w_bit_end    = w_tick && (r_samp_cnt == 4'd15);
  assign w_start_edge = r_s_d && !r_s;

  // Samples 7 and 8 are held; sample 9 is the live line value on the deciding tick
  assign w_maj = (r_s7 & r_s8) | (r_s7 & r_s) | (r_s8 & r_s);

  // XOR over data and received parity bit: odd mode wants 1, even mode wants 0
  assign w_par_x   = (^r_shift) ^ w_maj;
  assign w_par_err = (PARITY == PAR_ODD) ? ~w_par_x : w_par_x;

  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));

  // Push is decided combinationally on the final stop-bit decision so the entry
  // lands in the FIFO on that same edge; the last stop bit folds into ferr here
  assign w_push     = (r_state == ST_STOP) && w_decide && w_last_stop;
  assign w_push_dat = {r_ferr | ~w_maj, r_perr, r_shift};

  assign w_pop = !w_empty && rx_if.ready;

  // Synchronize the asynchronous serial line and keep a delayed copy for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_s     <= 1'b1;
      r_s_d   <= 1'b1;
    end else begin
      r_sync1 <= data_in;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
    end
  end

  // Capture the first two of the three majority samples within each bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s7 <= 1'b0;
      r_s8 <= 1'b0;
    end else if (w_tick) begin
      if (r_samp_cnt == 4'd7) begin
        r_s7 <= r_s;
      end
      if (r_samp_cnt == 4'd8) begin
        r_s8 <= r_s;
      end
    end
  end

  // Receive FSM with oversampling counters, shift register and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (r_state != ST_IDLE) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_tick) begin
          r_samp_cnt <= r_samp_cnt + 4'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          // Falling edge needs s_d=1, so a held-low line cannot retrigger
          if (w_start_edge) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ST_START: begin
          // A start bit that votes high was a glitch: drop it without output
          if (w_decide && w_maj) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_bit_end) begin
            r_state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_decide) begin
            r_shift <= {w_maj, r_shift[WIDTH-1:1]};
          end
          if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BW'(WIDTH - 1)) begin
              r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
          end
        end

        ST_PARITY: begin
          if (w_decide) begin
            r_perr <= w_par_err;
          end
          if (w_bit_end) begin
            r_state <= ST_STOP;
          end
        end

        ST_STOP: begin
          // Leaving at count 9 of the last stop bit rearms edge detection early
          if (w_decide) begin
            if (w_last_stop) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ferr <= r_ferr | ~w_maj;
            end
          end else if (w_bit_end) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  uart_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (w_push),
    .wr_dat (w_push_dat),
    .pop    (w_pop),
    .rd_dat (w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign rx_if.data_out = w_head[WIDTH-1:0];
  assign rx_if.perr_out = w_head[WIDTH];
  assign rx_if.ferr_out = w_head[WIDTH+1];
  assign rx_if.valid    = !w_empty;
  assign rx_if.busy     = r_busy;

  // Overrun flags the rejected push in the same cycle it is attempted
  assign rx_if.overrun  = w_push && w_full && !w_pop;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: one instance without parity, one with even parity.
// Latency: entries are compared as the consumer pops them.
// Backpressure: ready is held low in the overrun and reset scenarios.
module tb_uart_rx_os;

  localparam int BIT_CLK = 160;

  logic clk = 1'b0;
  logic rst;
  logic line0;
  logic line1;

  uart_rx_os_if #(.WIDTH(8)) bus0 ();
  uart_rx_os_if #(.WIDTH(8)) bus1 ();

  uart_rx_os #(
    .CLOCK_FREQ (1600000),
    .BAUD       (10000),
    .WIDTH      (8),
    .PARITY     (0),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (line0),
    .rx_if   (bus0)
  );

  uart_rx_os #(
    .CLOCK_FREQ (1600000),
    .BAUD       (10000),
    .WIDTH      (8),
    .PARITY     (2),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) u_dut_par (
    .clk     (clk),
    .rst     (rst),
    .data_in (line1),
    .rx_if   (bus1)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_ovr0  = 0;
  int ovr_frame = 0;
  int cur_frame = 0;
  int n_vld0  = 0;

  // Expected entries {ferr, perr, data}
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [10:0] e0;
  logic [10:0] e1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_line(input bit sel, input logic v, input int nclk);
    if (sel) line1 = v;
    else     line0 = v;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en, input logic par_bit);
    drive_line(sel, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_line(sel, d[i], BIT_CLK);
    if (par_en) drive_line(sel, par_bit, BIT_CLK);
    drive_line(sel, 1'b1, BIT_CLK);
  endtask

  // Consumer-side monitor, sampled just after the falling edge
  always begin
    @(negedge clk);
    #1;
    if (rst === 1'b0) begin
      if (bus0.valid) n_vld0++;
      if (bus0.overrun) begin
        n_ovr0++;
        ovr_frame = cur_frame;
      end
      if (bus0.valid && bus0.ready) begin
        if (q0.size() > 0) e0 = {1'b0, q0.pop_front()};
        else               e0 = 11'h400;
        chk("rx0_entry", {21'b0, 1'b0, bus0.ferr_out, bus0.perr_out, bus0.data_out}, {21'b0, e0});
      end
      if (bus1.valid && bus1.ready) begin
        if (q1.size() > 0) e1 = {1'b0, q1.pop_front()};
        else               e1 = 11'h400;
        chk("rx1_entry", {21'b0, 1'b0, bus1.ferr_out, bus1.perr_out, bus1.data_out}, {21'b0, e1});
      end
    end
  end

  initial begin
    rst        = 1'b0;
    line0      = 1'b1;
    line1      = 1'b1;
    bus0.ready = 1'b0;
    bus1.ready = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid",   {31'b0, bus0.valid},    0);
    chk("rst_data",    {24'b0, bus0.data_out}, 0);
    chk("rst_perr",    {31'b0, bus0.perr_out}, 0);
    chk("rst_ferr",    {31'b0, bus0.ferr_out}, 0);
    chk("rst_overrun", {31'b0, bus0.overrun},  0);
    chk("rst_busy",    {31'b0, bus0.busy},     0);
    @(negedge clk);
    rst = 1'b0;
    bus0.ready = 1'b1;
    repeat (20) @(negedge clk);

    // Plain frame, no parity
    q0.push_back({2'b00, 8'h55});
    send_frame(1'b0, 8'h55, 1'b0, 1'b0);
    drive_line(1'b0, 1'b1, 40);
    chk("f55_valid_cycles", n_vld0, 1);
    chk("f55_no_overrun", n_ovr0, 0);
    chk("f55_drained", q0.size(), 0);

    // Short low glitch on idle line
    drive_line(1'b0, 1'b0, 20);
    chk("glitch_busy_hi", {31'b0, bus0.busy}, 1);
    drive_line(1'b0, 1'b0, 20);
    drive_line(1'b0, 1'b1, 300);
    chk("glitch_busy_lo", {31'b0, bus0.busy}, 0);
    chk("glitch_valid", {31'b0, bus0.valid}, 0);
    chk("glitch_vld_cycles", n_vld0, 1);

    // Even parity instance: bad parity then good parity
    q1.push_back({2'b01, 8'hA3});
    send_frame(1'b1, 8'hA3, 1'b1, 1'b1);
    q1.push_back({2'b00, 8'h07});
    send_frame(1'b1, 8'h07, 1'b1, 1'b1);
    drive_line(1'b1, 1'b1, 40);
    chk("par_drained", q1.size(), 0);

    // Break: 12 bit times low, one entry with ferr, then a clean byte
    q0.push_back({2'b10, 8'h00});
    drive_line(1'b0, 1'b0, 12 * BIT_CLK);
    chk("break_busy_lo", {31'b0, bus0.busy}, 0);
    drive_line(1'b0, 1'b1, 2 * BIT_CLK);
    q0.push_back({2'b00, 8'h41});
    send_frame(1'b0, 8'h41, 1'b0, 1'b0);
    drive_line(1'b0, 1'b1, 40);
    chk("break_drained", q0.size(), 0);

    // Overrun: consumer stalled, five back-to-back frames into a 4-deep FIFO
    bus0.ready = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      cur_frame = f;
      if (f <= 4) q0.push_back({2'b00, 8'(f)});
      send_frame(1'b0, 8'(f), 1'b0, 1'b0);
    end
    drive_line(1'b0, 1'b1, 20);
    chk("ovr_count", n_ovr0, 1);
    chk("ovr_frame", ovr_frame, 5);
    chk("ovr_head", {24'b0, bus0.data_out}, 32'h01);
    bus0.ready = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("ovr_drain_valid", {31'b0, bus0.valid}, 0);
    chk("ovr_drained", q0.size(), 0);

    // Reset during data bit 4 of a frame, with an undelivered entry pending
    @(negedge clk);
    bus0.ready = 1'b0;
    send_frame(1'b0, 8'h66, 1'b0, 1'b0);
    drive_line(1'b0, 1'b1, 5);
    chk("pre_rst_valid", {31'b0, bus0.valid}, 1);
    chk("pre_rst_data", {24'b0, bus0.data_out}, 32'h66);
    drive_line(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_line(1'b0, 1'(8'h7E >> i), BIT_CLK);
    drive_line(1'b0, 1'b1, 80);
    chk("mid_busy", {31'b0, bus0.busy}, 1);
    rst = 1'b1;
    #1;
    chk("mrst_valid",   {31'b0, bus0.valid},    0);
    chk("mrst_data",    {24'b0, bus0.data_out}, 0);
    chk("mrst_busy",    {31'b0, bus0.busy},     0);
    chk("mrst_overrun", {31'b0, bus0.overrun},  0);
    chk("mrst_ferr",    {31'b0, bus0.ferr_out}, 0);
    line0 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus0.ready = 1'b1;
    repeat (20) @(negedge clk);
    q0.push_back({2'b00, 8'h3C});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    drive_line(1'b0, 1'b1, 40);
    chk("post_rst_drained", q0.size(), 0);
    chk("post_rst_valid", {31'b0, bus0.valid}, 0);
    chk("final_ovr_count", n_ovr0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
